// File: rtl/peripheral_bfm_master_axi4.sv
// AXI4 master transaction engine: one command at a time (single or INCR burst, read or write),
// drives AW/W/B/AR/R and returns read beats and write responses on a registered response stream.
module peripheral_bfm_master_axi4 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    // write-data stream
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    // response stream
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_last,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic                    busy,
    output logic                    proto_err,
    // AW channel
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [LEN_WIDTH-1:0]    awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    // W channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // B channel
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // AR channel
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [LEN_WIDTH-1:0]    arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    // R channel
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int                   STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]           AXI_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0]           BURST_INCR = 2'b01;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [LEN_WIDTH-1:0]    beat_cnt;
    logic                    aw_done;
    logic                    w_done;
    logic                    rsp_free;
    logic                    cmd_hs;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    r_hs;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXI_SIZE;
    assign awburst = BURST_INCR;
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXI_SIZE;
    assign arburst = BURST_INCR;

    assign wdata = wd_data;
    assign wstrb = wd_strb;
    assign wlast = (beat_cnt == len_q);
    assign busy  = (state != IDLE);

    // A B/R beat may only be taken when the response register is free or draining this cycle.
    assign rsp_free = !rsp_valid || rsp_ready;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign r_hs   = rvalid && rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        arvalid    = 1'b0;
        wvalid     = 1'b0;
        wd_ready   = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                awvalid  = !aw_done;
                wvalid   = !w_done && wd_valid;
                wd_ready = !w_done && wready;
                // AW and the last W beat may complete in either order or in the same cycle.
                if ((aw_done || awready) &&
                    (w_done || (wd_valid && wready && (beat_cnt == len_q)))) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = rsp_free;
                if (bvalid && rsp_free) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = rsp_free;
                if (rvalid && rsp_free && rlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                id_q     <= cmd_id;
                beat_cnt <= '0;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + LEN_ONE;
                if (wlast) begin
                    w_done <= 1'b1;
                end
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + LEN_ONE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
            rsp_last  <= 1'b0;
            rsp_id    <= '0;
        end else if (b_hs) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_data  <= '0;
            rsp_resp  <= bresp;
            rsp_last  <= 1'b1;
            rsp_id    <= bid;
        end else if (r_hs) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_data  <= rdata;
            rsp_resp  <= rresp;
            rsp_last  <= rlast;
            rsp_id    <= rid;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Sticky until reset: wrong ID on B/R, early rlast, or missing rlast on the final beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            proto_err <= 1'b0;
        end else begin
            if (b_hs && (bid != id_q)) begin
                proto_err <= 1'b1;
            end
            if (r_hs && ((rid != id_q) ||
                         (rlast && (beat_cnt != len_q)) ||
                         (!rlast && (beat_cnt == len_q)))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/peripheral_bfm_master_axi4.md
Name: peripheral_bfm_master_axi4

Overview:
Parametrised synthesizable AXI4 master transaction engine for MPSoC peripheral bring-up and DMA verification. It accepts one command at a time (single or INCR burst, read or write) on a simple valid/ready command port, drives the five AXI4 channels, and returns read data and write responses on a registered response stream. It adds protocol checking (ID/last mismatch) and is the generalised successor of the fixed 32-bit AXI-Lite master shell.

Parameters:
ADDR_WIDTH, 32, address width of cmd_addr/awaddr/araddr
DATA_WIDTH, 32, data width (power of two, 8..1024); strobe width DATA_WIDTH/8
ID_WIDTH, 4, AXI ID width
LEN_WIDTH, 8, burst length field width (beats = len+1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cmd_valid / cmd_ready  in / out  1  command handshake
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  start address (size-aligned, no 4KB crossing; not checked)
cmd_len  in  LEN_WIDTH  beats minus one
cmd_id  in  ID_WIDTH  transaction ID
wd_valid / wd_ready  in / out  1  write-data stream handshake
wd_data  in  DATA_WIDTH  write beat data
wd_strb  in  DATA_WIDTH/8  write beat strobes
rsp_valid / rsp_ready  out / in  1  response handshake
rsp_write  out  1  1=B response, 0=R beat
rsp_data  out  DATA_WIDTH  read data (0 for B)
rsp_resp  out  2  bresp/rresp
rsp_last  out  1  last beat (1 for B)
rsp_id  out  ID_WIDTH  returned ID
busy  out  1  state != IDLE
proto_err  out  1  sticky protocol error
awid, awaddr, awlen, awsize, awburst, awvalid  out  ID/ADDR/LEN/3/2/1  AW channel; awready in 1
wdata, wstrb, wlast, wvalid  out  DATA/DATA/8/1/1  W channel; wready in 1
bid in ID_WIDTH, bresp in 2, bvalid in 1, bready out 1  B channel
arid, araddr, arlen, arsize, arburst, arvalid  out  ID/ADDR/LEN/3/2/1  AR channel; arready in 1
rid in ID_WIDTH, rdata in DATA_WIDTH, rresp in 2, rlast in 1, rvalid in 1, rready out 1  R channel

Behaviour:
- Reset (async, aresetn=0): state IDLE; all valid outputs, bready, rready, rsp_* , busy, proto_err, beat counter, latched addr/len/id = 0. In-flight transaction abandoned; no recovery.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/len/id, clear beat counter; next cycle WR (awvalid=1) or RD_ADDR (arvalid=1). One-cycle accept-to-valid latency.
- awsize/arsize = log2(DATA_WIDTH/8); awburst/arburst = 2'b01 (INCR) constant; awlen/arlen = latched len.
- awvalid/arvalid held high, address stable, until ready sampled high, then deasserted next cycle.
- WR: W independent of AW (beats may precede or follow awready). While beats remain: wvalid=wd_valid, wd_ready=wready, wdata/wstrb=wd_data/wd_strb (combinational pass-through); wlast=(beat_cnt==len). Beat counter increments on wvalid&wready. After last beat: wvalid=0, wd_ready=0.
- WR -> WR_RESP in the cycle after both AW handshake and last W beat are done (same-cycle completion allowed).
- WR_RESP: bready = !rsp_valid | rsp_ready. On bvalid&bready: register rsp (rsp_write=1, rsp_last=1, rsp_data=0, rsp_resp=bresp, rsp_id=bid) -> IDLE. bid != latched id sets proto_err.
- RD_ADDR -> RD_DATA after arready. RD_DATA: rready = !rsp_valid | rsp_ready; each rvalid&rready registers one rsp beat (rsp_write=0, data/resp/last/id from R), increments counter. On rlast -> IDLE.
- proto_err set (sticky until reset) on: rid/bid mismatch; rlast with beat_cnt != len; beat with beat_cnt==len and rlast=0 (state stays RD_DATA until rlast).
- rsp_valid cleared on rsp_ready with no new beat; full back-to-back throughput when rsp_ready=1.
- B/R beats outside WR_RESP/RD_DATA are not accepted (bready/rready=0).

Test Plan:
- Single write: cmd addr=0x100, len=0, id=3, data 0xDEADBEEF strb 0xF; awready 2 cycles late -> awaddr=0x100 awlen=0, one W beat wlast=1, bresp=0 bid=3 -> rsp_write=1 rsp_id=3, proto_err=0.
- Burst read len=3 at 0x2000, slave returns 0xA0..0xA3 with rlast on 4th, rsp_ready=1 -> four rsp beats back-to-back, rsp_last only on 4th, busy drops the cycle after.
- Write data ahead of address: 4-beat write, wready=1 and awready held low 6 cycles -> all 4 W beats complete before AW, WR_RESP entered only after awready.
- Backpressure: burst read with rsp_ready toggling 1/0 -> rready follows, no beat lost or duplicated, order 0..N preserved.
- Protocol errors: read len=1 with rlast on first beat -> proto_err=1 and returns IDLE; bid=5 for id=3 -> proto_err=1.
- Reset mid-burst: aresetn low during beat 2 of 4 -> all valids 0 asynchronously, state IDLE, cmd_ready=1 after release.
